mux4a2_cond_l1tx: RTL and testbench
===================================

// Module: mux4a2_cond_l1tx
// PURPOSE
//   Transmit-side L1 lane concentrator: merges four 8-bit byte lanes into two lanes.
//   Output lane 0 is fed by inputs 0/1; output lane 1 is fed by inputs 2/3.
//   Each input has a small FIFO with valid/ready flow control.
//   Each output pair uses a round-robin arbiter and carries a source-lane tag.
//   Sits ahead of the TX serializer. Mirrors the RX 2-to-4 demux stage.
// PARAMETERS
//   DATA_W      8      byte width of every data lane
//   FIFO_DEPTH  4      entries per input FIFO (power of 2, >=2)
//   IDLE_CHAR   8'h7C  filler byte driven on idle output cycles (IDLE_INSERT_EN only)
// PORTS
//   clk_2f            in   1        single clock, output-lane byte rate
//   reset             in   1        synchronous reset, active-high
//   validin0..3       in   1        input lane n byte valid
//   datain0..3        in   DATA_W   input lane n byte
//   readyin0..3       out  1        input lane n may accept a byte this cycle
//   validout0/1       out  1        output lane k carries a real byte
//   dataout0/1        out  DATA_W   output lane k byte
//   srcout0/1         out  1        source of the byte on lane k: 0=even input, 1=odd input
// BEHAVIOUR
//   Clock, reset and outputs
//   - One clock, clk_2f. Reset is synchronous and active-high.
//   - While reset=1 at a rising edge: all FIFOs empty, both RR pointers=0 (even input).
//   - Reset values: validout*=0, dataout*=0, srcout*=0. readyin*=0 while reset is high.
//   - Reset mid-stream discards all buffered bytes; no partial output follows.
//   Input side
//   - readyinN = !fullN & !reset (combinational).
//   - Push occurs when validinN & readyinN at a rising edge.
//   - A full FIFO refuses the push even if it pops in the same cycle (conservative ready).
//   - validin while not ready: byte is not taken; the sender must hold it.
//   FIFO and arbitration
//   - FIFO is a circular buffer. Read/write pointers wrap modulo FIFO_DEPTH.
//   - An occupancy counter of clog2(FIFO_DEPTH)+1 bits distinguishes full from empty.
//   - Simultaneous push+pop on a non-full FIFO leaves the count unchanged.
//   - Arbiter per output k: candidates are inputs 2k (ptr=0) and 2k+1 (ptr=1).
//     - Preferred input non-empty: pop it.
//     - Else other input non-empty: pop it.
//     - Else idle.
//     - After any pop, ptr <= !(served lane). Ptr holds when idle.
//   - Both outputs arbitrate independently in the same cycle.
//   Output and latency
//   - Outputs are registered. A pop at edge t drives validoutk=1, dataoutk=byte,
//     srcoutk=served lane, visible from t until t+1.
//   - Latency: a byte pushed at edge t is eligible at edge t+1 (minimum 1 cycle).
//   - Fairness: both inputs of a pair continuously non-empty -> strict alternation
//     even, odd, even, ...
//   - Per-input byte order is preserved. Ordering across inputs follows the RR rule only.
//   - Idle cycle: validoutk=0, srcoutk holds its last value.
// CONFIGURATION
//   IDLE_INSERT_EN defined:
//   - On idle cycles dataoutk = IDLE_CHAR, so the line always carries a comma/filler.
//   IDLE_INSERT_EN undefined:
//   - On idle cycles dataoutk = 0.
//   - IDLE_CHAR is unused.
//   - validout timing is identical in both builds.
// TESTING
//   T1 reset: hold reset 2 cycles with all validin=1
//      -> readyin*=0, validout*=0, dataout*=0, no push recorded.
//   T2 single byte: validin0=1, datain0=8'hA5 for 1 cycle
//      -> next cycle validout0=1, dataout0=A5, srcout0=0; lane 1 stays idle.
//   T3 alternation: inputs 2 and 3 stream 8'h10.. and 8'h20.. every cycle
//      -> dataout1 = 10,20,11,21,... and srcout1 = 0,1,0,1.
//   T4 backpressure: push 4 bytes into input 1 while output 0 is kept busy by input 0
//      -> readyin1=0 once count hits FIFO_DEPTH; 5th byte held; no loss, order kept.
//   T5 reset mid-stream: assert reset with all FIFOs partly full
//      -> next cycle all outputs=0; after release first output byte is a newly pushed one.
//   T6 idle fill: no input for 3 cycles
//      -> dataout*=8'h7C with IDLE_INSERT_EN, 8'h00 without; validout*=0 in both.

Source files
------------

// File: rtl/mux4a2_cond_l1tx.sv
// ---------------------------------------------------------------------------
// mux4a2_cond_l1tx
//   Transmit-side L1 lane concentrator. Four 8-bit input byte lanes are merged
//   onto two output lanes: output 0 is fed by inputs 0/1 and output 1 by
//   inputs 2/3. Each input has a small circular FIFO with valid/ready flow
//   control. Each output pair is served by a round-robin arbiter, and each
//   output byte carries a tag naming its source lane within the pair.
//
// Handshake: an input byte transfers on a rising edge where validinN and
//   readyinN are both 1. readyinN depends only on FIFO fullness and reset,
//   never on validinN. A sender that sees readyinN=0 must hold its byte.
//
// Build option:
//   IDLE_INSERT_EN  when defined, idle output cycles carry IDLE_CHAR on
//                   dataoutK; otherwise idle cycles carry 0. validout timing
//                   is the same in both builds.
//
// Ports:
//   clk_2f              in   1       single clock, output-lane byte rate
//   reset               in   1       synchronous reset, active-high
//   validin0..3         in   1       input lane n byte valid
//   datain0..3          in   DATA_W  input lane n byte
//   readyin0..3         out  1       input lane n may accept a byte
//   validout0/1         out  1       output lane k carries a real byte
//   dataout0/1          out  DATA_W  output lane k byte
//   srcout0/1           out  1       source of lane k byte: 0=even, 1=odd
// ---------------------------------------------------------------------------
module mux4a2_cond_l1tx #(
    parameter int                 DATA_W     = 8,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0]  IDLE_CHAR  = 8'h7C
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              validin0,
    input  logic              validin1,
    input  logic              validin2,
    input  logic              validin3,
    input  logic [DATA_W-1:0] datain0,
    input  logic [DATA_W-1:0] datain1,
    input  logic [DATA_W-1:0] datain2,
    input  logic [DATA_W-1:0] datain3,
    output logic              readyin0,
    output logic              readyin1,
    output logic              readyin2,
    output logic              readyin3,
    output logic              validout0,
    output logic              validout1,
    output logic [DATA_W-1:0] dataout0,
    output logic [DATA_W-1:0] dataout1,
    output logic              srcout0,
    output logic              srcout1
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // One extra count bit so a full FIFO is distinguishable from an empty one.
    localparam int CW = AW + 1;

`ifdef IDLE_INSERT_EN
    localparam bit IDLE_INSERT = 1'b1;
`else
    localparam bit IDLE_INSERT = 1'b0;
`endif

    localparam logic [DATA_W-1:0] IDLE_FILL = IDLE_INSERT ? IDLE_CHAR : '0;

    // ------------------------------------------------------------------
    // Input FIFO storage and state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q   [4][FIFO_DEPTH];
    logic [AW-1:0]     wptr_q  [4];
    logic [AW-1:0]     rptr_q  [4];
    logic [CW-1:0]     count_q [4];

    // Round-robin pointer per output: 0 prefers the even input, 1 the odd.
    logic [1:0]        rr_q;

    // Registered output lanes
    logic [1:0]        vout_q;
    logic [DATA_W-1:0] dout_q [2];
    logic [1:0]        sout_q;

    logic [3:0]        in_valid;
    logic [DATA_W-1:0] in_data [4];
    logic [3:0]        full;
    logic [3:0]        empty;
    logic [3:0]        ready;
    logic [3:0]        push;
    logic [3:0]        pop;
    logic [DATA_W-1:0] head [4];
    logic [1:0]        grant;
    logic [1:0]        sel;

    assign in_valid   = {validin3, validin2, validin1, validin0};
    assign in_data[0] = datain0;
    assign in_data[1] = datain1;
    assign in_data[2] = datain2;
    assign in_data[3] = datain3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i]  = (count_q[i] == CW'(FIFO_DEPTH));
            empty[i] = (count_q[i] == '0);
            head[i]  = mem_q[i][rptr_q[i]];
        end
    end

    // Ready ignores a same-cycle pop: a full FIFO never accepts, which keeps
    // ready free of any path from the arbiter.
    assign ready = ~full & {4{~reset}};
    assign push  = in_valid & ready;

    assign readyin0 = ready[0];
    assign readyin1 = ready[1];
    assign readyin2 = ready[2];
    assign readyin3 = ready[3];

    // ------------------------------------------------------------------
    // Arbitration: both pairs decide independently every cycle.
    // ------------------------------------------------------------------
    always_comb begin
        grant = '0;
        sel   = '0;
        pop   = '0;
        for (int k = 0; k < 2; k++) begin
            if (!empty[2*k + int'(rr_q[k])]) begin
                grant[k] = 1'b1;
                sel[k]   = rr_q[k];
            end else if (!empty[2*k + int'(!rr_q[k])]) begin
                grant[k] = 1'b1;
                sel[k]   = !rr_q[k];
            end
            if (grant[k]) begin
                pop[2*k + int'(sel[k])] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: push is already gated off during reset through ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= in_data[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, counts, arbiter pointers and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_q   <= '0;
            vout_q <= '0;
            sout_q <= '0;
            for (int k = 0; k < 2; k++) begin
                dout_q[k] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Depth is a power of two, so pointers wrap naturally.
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + 1'b1;
                    2'b01:   count_q[i] <= count_q[i] - 1'b1;
                    default: count_q[i] <= count_q[i];
                endcase
            end
            for (int k = 0; k < 2; k++) begin
                if (grant[k]) begin
                    vout_q[k] <= 1'b1;
                    dout_q[k] <= head[2*k + int'(sel[k])];
                    sout_q[k] <= sel[k];
                    // Next turn goes to the lane that was not just served.
                    rr_q[k]   <= !sel[k];
                end else begin
                    // Idle: source tag and arbiter pointer hold.
                    vout_q[k] <= 1'b0;
                    dout_q[k] <= IDLE_FILL;
                end
            end
        end
    end

    assign validout0 = vout_q[0];
    assign validout1 = vout_q[1];
    assign dataout0  = dout_q[0];
    assign dataout1  = dout_q[1];
    assign srcout0   = sout_q[0];
    assign srcout1   = sout_q[1];

endmodule

// File: tb/tb_mux4a2_cond_l1tx.sv
// ---------------------------------------------------------------------------
// tb_mux4a2_cond_l1tx
//   Directed bench for the 4-to-2 TX lane concentrator. Inputs change 1 ns
//   after a rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_mux4a2_cond_l1tx;

`ifdef IDLE_INSERT_EN
    localparam logic [7:0] FILL = 8'h7C;
`else
    localparam logic [7:0] FILL = 8'h00;
`endif

    logic       clk_2f = 1'b0;
    logic       reset;
    logic       validin0, validin1, validin2, validin3;
    logic [7:0] datain0, datain1, datain2, datain3;
    logic       readyin0, readyin1, readyin2, readyin3;
    logic       validout0, validout1;
    logic [7:0] dataout0, dataout1;
    logic       srcout0, srcout1;

    int checks = 0;
    int errors = 0;

    mux4a2_cond_l1tx dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .validin0  (validin0),
        .validin1  (validin1),
        .validin2  (validin2),
        .validin3  (validin3),
        .datain0   (datain0),
        .datain1   (datain1),
        .datain2   (datain2),
        .datain3   (datain3),
        .readyin0  (readyin0),
        .readyin1  (readyin1),
        .readyin2  (readyin2),
        .readyin3  (readyin3),
        .validout0 (validout0),
        .validout1 (validout1),
        .dataout0  (dataout0),
        .dataout1  (dataout1),
        .srcout0   (srcout0),
        .srcout1   (srcout1)
    );

    // ---------------- clock ----------------
    always #5 clk_2f = ~clk_2f;

    // ---------------- driver / check tasks ----------------
    task automatic step();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] exp);
        chk(tag, 32'({readyin3, readyin2, readyin1, readyin0}), 32'(exp));
    endtask

    task automatic chk_lane(input string tag, input int k, input logic v,
                            input logic [7:0] d, input logic s);
        logic       vo;
        logic [7:0] dv;
        logic       so;
        vo = (k == 0) ? validout0 : validout1;
        dv = (k == 0) ? dataout0  : dataout1;
        so = (k == 0) ? srcout0   : srcout1;
        chk($sformatf("%s_valid%0d", tag, k), 32'(vo), 32'(v));
        chk($sformatf("%s_data%0d",  tag, k), 32'(dv), 32'(d));
        chk($sformatf("%s_src%0d",   tag, k), 32'(so), 32'(s));
    endtask

    task automatic set_valid(input logic [3:0] v);
        validin0 = v[0];
        validin1 = v[1];
        validin2 = v[2];
        validin3 = v[3];
    endtask

    // T3 expected order on output 1 (inputs 2/3 each send four bytes)
    logic [7:0] t3_data [8] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};

    // T4 expected order on output 0: arbiter starts preferring input 1
    logic [7:0] t4_data [16] = '{8'h40, 8'h30, 8'h41, 8'h31, 8'h42, 8'h32, 8'h43, 8'h33,
                                 8'h44, 8'h34, 8'h45, 8'h35, 8'h46, 8'h36, 8'h47, 8'h37};
    // T4 readyin0/readyin1 after each edge e (bit e)
    logic [17:0] t4_rdy0 = 18'b11111111_0_1_0_1_0_11111;
    logic [17:0] t4_rdy1 = 18'b111111111_0_1_0_111111;

    initial begin
        int  sent0, sent1;
        logic acc0, acc1;

        // ---------------- T1: reset with all inputs valid ----------------
        reset = 1'b1;
        set_valid(4'hF);
        datain0 = 8'hFF; datain1 = 8'hFE; datain2 = 8'hFD; datain3 = 8'hFC;
        #1;
        chk_rdy("t1_ready_in_reset", 4'h0);
        step();
        chk_lane("t1_rst_a", 0, 1'b0, 8'h00, 1'b0);
        chk_lane("t1_rst_a", 1, 1'b0, 8'h00, 1'b0);
        step();
        chk_lane("t1_rst_b", 0, 1'b0, 8'h00, 1'b0);
        chk_lane("t1_rst_b", 1, 1'b0, 8'h00, 1'b0);
        chk_rdy("t1_ready_in_reset_b", 4'h0);
        reset = 1'b0;
        set_valid(4'h0);
        #1;
        chk_rdy("t1_ready_after_release", 4'hF);
        step();
        // Nothing was pushed during reset, so nothing comes out.
        chk_lane("t1_no_push", 0, 1'b0, FILL, 1'b0);
        chk_lane("t1_no_push", 1, 1'b0, FILL, 1'b0);

        // ---------------- T2: single byte on input 0 ----------------
        validin0 = 1'b1;
        datain0  = 8'hA5;
        step();
        validin0 = 1'b0;
        chk_lane("t2_push_edge", 0, 1'b0, FILL, 1'b0);
        step();
        chk_lane("t2_out", 0, 1'b1, 8'hA5, 1'b0);
        chk_lane("t2_out", 1, 1'b0, FILL, 1'b0);
        step();
        chk_lane("t2_after", 0, 1'b0, FILL, 1'b0);

        // ---------------- T3: alternation on inputs 2/3 ----------------
        for (int s = 0; s < 9; s++) begin
            if (s < 4) begin
                validin2 = 1'b1; datain2 = 8'(8'h10 + s);
                validin3 = 1'b1; datain3 = 8'(8'h20 + s);
                #0;
                chk($sformatf("t3_ready2_s%0d", s), 32'(readyin2), 32'd1);
                chk($sformatf("t3_ready3_s%0d", s), 32'(readyin3), 32'd1);
            end else begin
                validin2 = 1'b0;
                validin3 = 1'b0;
            end
            step();
            if (s == 0) begin
                chk_lane("t3_first_edge", 1, 1'b0, FILL, 1'b0);
            end else begin
                chk_lane($sformatf("t3_s%0d", s), 1, 1'b1, t3_data[s-1], 1'((s - 1) % 2));
            end
            chk($sformatf("t3_lane0_idle_s%0d", s), 32'(validout0), 32'd0);
        end
        step();
        chk_lane("t3_idle", 1, 1'b0, FILL, 1'b1);

        // ---------------- T4: backpressure on inputs 0/1 ----------------
        sent0 = 0;
        sent1 = 0;
        for (int e = 0; e < 18; e++) begin
            validin0 = (sent0 < 8);
            datain0  = 8'(8'h30 + sent0);
            validin1 = (sent1 < 8);
            datain1  = 8'(8'h40 + sent1);
            #0;
            acc0 = validin0 & readyin0;
            acc1 = validin1 & readyin1;
            step();
            if (acc0) sent0++;
            if (acc1) sent1++;
            chk($sformatf("t4_ready0_e%0d", e), 32'(readyin0), 32'(t4_rdy0[e]));
            chk($sformatf("t4_ready1_e%0d", e), 32'(readyin1), 32'(t4_rdy1[e]));
            if (e == 0 || e == 17) begin
                chk_lane($sformatf("t4_idle_e%0d", e), 0, 1'b0, FILL, 1'b0);
            end else begin
                chk_lane($sformatf("t4_e%0d", e), 0, 1'b1, t4_data[e-1], 1'(e % 2));
            end
            chk($sformatf("t4_lane1_idle_e%0d", e), 32'(validout1), 32'd0);
        end
        chk("t4_all_sent0", 32'(sent0), 32'd8);
        chk("t4_all_sent1", 32'(sent1), 32'd8);

        // ---------------- T5: reset mid-stream ----------------
        for (int f = 0; f < 2; f++) begin
            set_valid(4'hF);
            datain0 = 8'(8'h50 + f);
            datain1 = 8'(8'h60 + f);
            datain2 = 8'(8'h70 + f);
            datain3 = 8'(8'h80 + f);
            step();
        end
        // Output 0 prefers input 1 (last served 0), output 1 prefers input 2.
        chk_lane("t5_pre_reset", 0, 1'b1, 8'h60, 1'b1);
        chk_lane("t5_pre_reset", 1, 1'b1, 8'h70, 1'b0);
        set_valid(4'h0);
        reset = 1'b1;
        #0;
        chk_rdy("t5_ready_in_reset", 4'h0);
        step();
        chk_lane("t5_reset", 0, 1'b0, 8'h00, 1'b0);
        chk_lane("t5_reset", 1, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        step();
        chk_lane("t5_no_leftover", 0, 1'b0, FILL, 1'b0);
        chk_lane("t5_no_leftover", 1, 1'b0, FILL, 1'b0);
        validin1 = 1'b1; datain1 = 8'hC3;
        validin3 = 1'b1; datain3 = 8'hD3;
        step();
        set_valid(4'h0);
        chk_lane("t5_push_edge", 0, 1'b0, FILL, 1'b0);
        step();
        // A stale byte left in input 0 or 2 would win here (pointers reset to even).
        chk_lane("t5_new_byte", 0, 1'b1, 8'hC3, 1'b1);
        chk_lane("t5_new_byte", 1, 1'b1, 8'hD3, 1'b1);

        // ---------------- T6: idle fill ----------------
        for (int i = 0; i < 3; i++) begin
            step();
            chk_lane($sformatf("t6_idle%0d", i), 0, 1'b0, FILL, 1'b1);
            chk_lane($sformatf("t6_idle%0d", i), 1, 1'b0, FILL, 1'b1);
        end

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
